operand_sender: RTL and testbench
=================================

# operand_sender

Transmit-side counterpart of the operand change detector. It buffers operand pairs from an upstream producer in a small FIFO and drives them onto the 8-bit `a`/`b` operand bus one pair at a time. Each pair is held stable for a programmable minimum number of cycles, so the downstream register-and-compare stage sees every pair. A registered `update` pulse marks each cycle in which the driven pair changes value.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `HOLD`, 3 — minimum cycles each popped pair stays on `a`/`b`; ≥1.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — reset is asynchronous and active-low.
- `in_valid` input 1 — upstream pair valid.
- `in_a` input 8 — upstream operand a.
- `in_b` input 8 — upstream operand b.
- `in_ready` output 1 — FIFO can accept; equals !full.
- `a` output 8 — driven operand a (registered).
- `b` output 8 — driven operand b (registered).
- `update` output 1 — one-cycle pulse, high in the first cycle a new differing pair is driven.
- `busy` output 1 — state==HOLD or FIFO non-empty.
- `count` output $clog2(DEPTH)+1 — FIFO occupancy.

## Operation
- Push: edge with `in_valid && in_ready` writes {in_a,in_b} at tail. No push when full, even if a pop occurs that same edge.
- FSM states IDLE, HOLD; cnt register width $clog2(HOLD)+1.
- IDLE, FIFO empty: stay; a/b keep last value.
- IDLE, FIFO non-empty: pop head; a/b ← head; cnt ← HOLD-1; state ← HOLD.
- HOLD, cnt≠0: cnt ← cnt-1.
- HOLD, cnt==0, non-empty: pop back-to-back (same as IDLE pop).
- HOLD, cnt==0, empty: state ← IDLE.
- update ← 1 on a pop edge iff head ≠ {a,b} currently driven; else 0. update is 0 on all non-pop edges.
- Simultaneous push and pop on a non-full FIFO: both occur; count unchanged.
- Push into an empty FIFO while idle: the entry is popped on the following edge. Same-edge bypass is not allowed.
- Pointers wrap modulo DEPTH; count distinguishes full (DEPTH) from empty (0).

## Timing
- Reset values (asynchronous, while rst=0): a=0, b=0, update=0, count=0, in_ready=1, busy=0, state IDLE, cnt=0, pointers 0.
- Reset asserted mid-operation flushes all queued pairs. No pop happens on the first edge after release unless data was pushed.
- First-word latency: push at edge N, a/b and update valid after edge N+1.
- Pair period with backlog: exactly HOLD cycles (HOLD=1 → one pair per cycle).
- in_ready and busy are combinational from registered state. a, b, update are registered.
- Initial bus value is 0, so a first pair of {0,0} gives update=0.

## Configuration
- `OPERAND_SENDER_SKIP_DUP_EN` defined: a popped pair equal to the current {a,b} is discarded with no hold time.
  - The FSM pops again on the next edge if non-empty, else goes to IDLE.
  - a/b unchanged, update=0.
  - Each non-duplicate pair therefore always raises update.
- Undefined: duplicates are popped, held HOLD cycles, update=0 (behaviour above).

## Test plan
- Reset then idle: rst low 3 cycles, release, no input → a=0, b=0, update=0, in_ready=1, busy=0, count=0 for 10 cycles.
- Single pair: push {0x12,0x34} at edge N → a=0x12, b=0x34, update=1 for exactly one cycle after edge N+1; busy low after HOLD cycles.
- Backlog, HOLD=3: push 0x01/0x02, 0x03/0x04, 0x05/0x06 back-to-back → pairs change every 3 cycles, 3 update pulses, FIFO drains to count=0.
- Full/backpressure, DEPTH=4: push 6 pairs with the first popped → in_ready=0 when count=4; held in_valid pairs accepted only after pops; no pair lost or reordered.
- Duplicate pair: push 0x55/0xAA twice → without macro, a/b stable 2·HOLD cycles, single update pulse; with `OPERAND_SENDER_SKIP_DUP_EN`, a/b stable HOLD cycles, second entry consumed one cycle later, no second update.
- Reset mid-operation: 3 pairs queued, rst low for 1 cycle during HOLD → a=b=0, count=0, state IDLE immediately; queued pairs never appear after release.

Source files
------------

// File: rtl/operand_sender_if.sv
// ----------------------------------------------------------------------------
// operand_sender_if
//
// Purpose : Groups the upstream push handshake and the driven operand bus of
//           operand_sender into one bundle.
//
// Signals : in_valid / in_a / in_b  - upstream pair offered to the FIFO
//           in_ready                - FIFO can accept (not full)
//           a / b                   - operand pair driven downstream
//           update                  - one-cycle pulse when the driven pair changes
//           busy                    - a pair is being held or pairs are queued
//           count                   - FIFO occupancy, 0..DEPTH
//
// Modports: master - producer/observer side (drives in_*, reads the rest)
//           slave  - operand_sender side
// ----------------------------------------------------------------------------
interface operand_sender_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          in_ready;
  logic [7:0]    a;
  logic [7:0]    b;
  logic          update;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, a, b, update, busy, count
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, a, b, update, busy, count
  );
endinterface

// File: rtl/operand_sender.sv
// ----------------------------------------------------------------------------
// operand_sender
//
// Purpose : Buffers operand pairs from an upstream producer in a DEPTH-entry
//           FIFO and drives them onto the 8-bit a/b bus one pair at a time.
//           Each popped pair is held for at least HOLD cycles so a downstream
//           register-and-compare stage sees every pair. A registered update
//           pulse marks the cycle in which the driven pair changes value.
//
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous, active-low reset
//           bus  - operand_sender_if.slave (push handshake, a/b bus, status)
//
// Params  : DEPTH - FIFO entries, power of two, >= 2
//           HOLD  - minimum cycles each popped pair stays on a/b, >= 1
//
// Config  : OPERAND_SENDER_SKIP_DUP_EN - when defined, a popped pair equal to
//           the pair currently driven is discarded with no hold time.
// ----------------------------------------------------------------------------
module operand_sender #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  operand_sender_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD) + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] cnt_q,    cnt_d;
  logic [7:0]    a_q,      a_d;
  logic [7:0]    b_q,      b_d;
  logic          update_q, update_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic [15:0]   mem [DEPTH];

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic          dup;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  // Push is gated by the pre-edge full flag, so a pop on the same edge
  // never frees room for a push into a full FIFO.
  assign push  = bus.in_valid && !full;
  assign head  = mem[rd_ptr_q];
  assign dup   = (head == {a_q, b_q});

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    update_d = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HW'(1);
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      state_d  = S_HOLD;
`ifdef OPERAND_SENDER_SKIP_DUP_EN
      if (dup) begin
        // Duplicate is dropped: zero hold lets the next edge pop again
        // or fall back to idle.
        cnt_d = '0;
      end else begin
        a_d      = head[15:8];
        b_d      = head[7:0];
        update_d = 1'b1;
        cnt_d    = HOLD_LOAD;
      end
`else
      a_d      = head[15:8];
      b_d      = head[7:0];
      update_d = !dup;
      cnt_d    = HOLD_LOAD;
`endif
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      update_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      update_q <= update_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count and pointers define which
  // entries are valid, so clearing it would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {bus.in_a, bus.in_b};
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready = !full;
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.update   = update_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q == S_HOLD) || !empty;

endmodule

// File: tb/tb_operand_sender.sv
// ----------------------------------------------------------------------------
// tb_operand_sender
//
// Self-checking bench for operand_sender. A queue-based reference model tracks
// the FIFO contents, the pair on the bus and the earliest edge at which the
// next pop may happen; outputs are compared one time unit after each edge.
// ----------------------------------------------------------------------------
module tb_operand_sender;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;

`ifdef OPERAND_SENDER_SKIP_DUP_EN
  localparam bit SKIP_DUP = 1'b1;
`else
  localparam bit SKIP_DUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  operand_sender_if #(.DEPTH(DEPTH)) bus ();

  operand_sender #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [15:0] mq[$];     // queued pairs, head at index 0
  logic [15:0] m_bus;     // pair currently driven on a/b
  logic        m_update;
  int          m_t;       // index of the most recent edge since reset
  int          m_next;    // earliest edge index at which a pop may occur
  bit          m_pushed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bus    = '0;
    m_update = 1'b0;
    m_t      = 0;
    m_next   = 0;
    m_pushed = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge model state.
  task automatic model_edge(input logic v, input logic [7:0] ia, input logic [7:0] ib);
    logic [15:0] head;
    bit          full;
    bit          do_pop;
    m_t++;
    full     = (mq.size() == DEPTH);
    do_pop   = (mq.size() != 0) && (m_t >= m_next);
    m_pushed = v && !full;
    m_update = 1'b0;
    if (do_pop) begin
      head = mq.pop_front();
      if (SKIP_DUP && head == m_bus) begin
        m_next = m_t + 1;
      end else begin
        m_update = (head != m_bus);
        m_bus    = head;
        m_next   = m_t + HOLD;
      end
    end
    if (m_pushed) mq.push_back({ia, ib});
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".a"},        32'(bus.a),        32'(m_bus[15:8]));
    check({tag, ".b"},        32'(bus.b),        32'(m_bus[7:0]));
    check({tag, ".update"},   32'(bus.update),   32'(m_update));
    check({tag, ".count"},    32'(bus.count),    32'(mq.size()));
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    check({tag, ".busy"},     32'(bus.busy),     32'((mq.size() != 0) || (m_next > m_t)));
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] ia, input logic [7:0] ib);
    bus.in_valid = v;
    bus.in_a     = ia;
    bus.in_b     = ib;
    @(posedge clk);
    model_edge(v, ia, ib);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".a"},        32'(bus.a),        32'h0);
    check({tag, ".b"},        32'(bus.b),        32'h0);
    check({tag, ".update"},   32'(bus.update),   32'h0);
    check({tag, ".count"},    32'(bus.count),    32'h0);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'h1);
    check({tag, ".busy"},     32'(bus.busy),     32'h0);
  endtask

  initial begin
    int idx;
    int guard;
    logic [7:0] pa [6];
    logic [7:0] pb [6];

    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    model_reset();

    // Reset, then idle
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("in_reset");
    @(negedge clk);
    rst = 1'b1;
    idle("idle_after_reset", 10);

    // Single pair
    step("single_push", 1'b1, 8'h12, 8'h34);
    idle("single_drain", HOLD + 3);

    // Backlog
    step("backlog", 1'b1, 8'h01, 8'h02);
    step("backlog", 1'b1, 8'h03, 8'h04);
    step("backlog", 1'b1, 8'h05, 8'h06);
    idle("backlog_drain", 4 * HOLD + 2);

    // Full / backpressure: hold in_valid until each pair is accepted
    for (int i = 0; i < 6; i++) begin
      pa[i] = 8'(8'hA0 + i);
      pb[i] = 8'(8'hB0 + i);
    end
    idx   = 0;
    guard = 0;
    while (idx < 6 && guard < 60) begin
      step("full", 1'b1, pa[idx], pb[idx]);
      if (m_pushed) idx++;
      guard++;
    end
    check("full.all_accepted", 32'(idx), 32'd6);
    idle("full_drain", 6 * HOLD + 3);

    // Duplicate pair
    step("dup", 1'b1, 8'h55, 8'hAA);
    step("dup", 1'b1, 8'h55, 8'hAA);
    idle("dup_drain", 2 * HOLD + 3);

    // First pair equal to the initial bus value after reset
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("zero_pair_reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step("zero_pair", 1'b1, 8'h00, 8'h00);
    idle("zero_pair_drain", HOLD + 2);

    // Randomized traffic from a small value set so duplicates are frequent
    for (int i = 0; i < 400; i++) begin
      step("random", ($urandom_range(0, 99) < 55),
           8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)));
    end
    idle("random_drain", DEPTH * HOLD + 4);

    // Reset mid-operation
    step("mid_rst_fill", 1'b1, 8'h11, 8'h22);
    step("mid_rst_fill", 1'b1, 8'h33, 8'h44);
    step("mid_rst_fill", 1'b1, 8'h55, 8'h66);
    step("mid_rst_fill", 1'b1, 8'h77, 8'h88);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle("after_mid_rst", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
